// File: rtl/i2s_frame_buffer_pkg.sv
// Shared defaults, FSM encoding and bank-ordering helper for the I2S frame buffer.
// The optional dropped-sample counter is enabled with I2S_FRAME_OVERRUN_CNT_EN.
package i2s_frame_buffer_pkg;

    localparam int unsigned DATA_BITS_DEF = 16;
    localparam int unsigned FRAME_LEN_DEF = 256;
    localparam int unsigned OVR_CNT_BITS  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_FILL  = 2'd2,
        ST_STALL = 2'd3
    } state_e;

    // Banks always fill alternately, so with both full the write pointer sits on the older one.
    function automatic logic oldest_bank(input logic [1:0] full, input logic wr_bank);
        if (&full) begin
            return wr_bank;
        end
        return full[1];
    endfunction

endpackage

// File: rtl/i2s_frame_buffer_dpram.sv
// Simple dual-port frame RAM: one write port, one registered read port, both on clk.
// Address is {bank, index}; contents are never cleared.
module i2s_frame_buffer_dpram
    import i2s_frame_buffer_pkg::*;
#(
    parameter int unsigned DATA_BITS = DATA_BITS_DEF,
    parameter int unsigned ADDR_BITS = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en_i,
    input  logic [ADDR_BITS-1:0] wr_addr_i,
    input  logic [DATA_BITS-1:0] wr_data_i,
    input  logic [ADDR_BITS-1:0] rd_addr_i,
    output logic [DATA_BITS-1:0] rd_data_o
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [DATA_BITS-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/i2s_frame_buffer.sv
// I2S sample-pair capture, mono mix and ping-pong frame buffering for the FFT stage.
// Define I2S_FRAME_OVERRUN_CNT_EN to add the saturating overrun_cnt_o port.
module i2s_frame_buffer
    import i2s_frame_buffer_pkg::*;
#(
    parameter  int unsigned DATA_BITS = DATA_BITS_DEF,
    parameter  int unsigned FRAME_LEN = FRAME_LEN_DEF,
    localparam int unsigned ADDR_BITS = $clog2(FRAME_LEN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_i,
    output logic                 i2s_get_o,
    input  logic [DATA_BITS-1:0] i2s_sample_data_L_i,
    input  logic [DATA_BITS-1:0] i2s_sample_data_R_i,
    input  logic                 i2s_done_i,
    output logic                 sample_valid_o,
    output logic                 frame_ready_o,
    output logic                 frame_bank_o,
    input  logic [ADDR_BITS-1:0] frame_rd_addr_i,
    output logic [DATA_BITS-1:0] frame_rd_data_o,
    input  logic                 frame_release_i,
    output logic                 overrun_o
`ifdef I2S_FRAME_OVERRUN_CNT_EN
    ,
    output logic [OVR_CNT_BITS-1:0] overrun_cnt_o
`endif
);

    localparam int unsigned SUM_BITS = DATA_BITS + 1;
    localparam int unsigned RAM_ADDR_BITS = ADDR_BITS + 1;

    // sync_q[0..1] is the 2-FF synchronizer, sync_q[2] the edge-detect delay
    logic [2:0]           sync_q;
    logic                 done_edge_c;
    logic                 edge_q;
    logic signed [SUM_BITS-1:0] sum_c;
    logic [DATA_BITS-1:0] mono_c;
    logic [DATA_BITS-1:0] mono_q;
    logic                 get_q;

    state_e               state_q, state_d;
    logic                 wr_bank_q, wr_bank_d;
    logic [ADDR_BITS-1:0] wr_idx_q, wr_idx_d;
    logic [1:0]           full_q, full_d;
    logic                 valid_q, valid_d;
    logic                 ready_q;
    logic                 bank_q;
    logic                 overrun_q, overrun_d;
    logic                 wr_en_c;
    logic                 release_c;
`ifdef I2S_FRAME_OVERRUN_CNT_EN
    logic [OVR_CNT_BITS-1:0] cnt_q, cnt_d;
`endif

    assign done_edge_c = sync_q[1] & ~sync_q[2];

    // Sign-extended sum keeps the extra bit so the arithmetic halve cannot overflow.
    assign sum_c  = $signed({i2s_sample_data_L_i[DATA_BITS-1], i2s_sample_data_L_i})
                  + $signed({i2s_sample_data_R_i[DATA_BITS-1], i2s_sample_data_R_i});
    assign mono_c = sum_c[DATA_BITS:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            edge_q <= 1'b0;
            mono_q <= '0;
            get_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], i2s_done_i};
            edge_q <= done_edge_c;
            get_q  <= enable_i;
            if (done_edge_c) begin
                mono_q <= mono_c;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        wr_idx_d  = wr_idx_q;
        full_d    = full_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;
        wr_en_c   = 1'b0;
`ifdef I2S_FRAME_OVERRUN_CNT_EN
        cnt_d     = cnt_q;
`endif
        release_c = frame_release_i & ready_q;
        if (release_c) begin
            full_d[bank_q] = 1'b0;
        end

        if (!enable_i) begin
            state_d  = ST_IDLE;
            wr_idx_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (edge_q) begin
                        state_d = full_d[wr_bank_q] ? ST_STALL : ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (edge_q) begin
                        wr_en_c = 1'b1;
                        valid_d = 1'b1;
                        if (wr_idx_q == ADDR_BITS'(FRAME_LEN - 1)) begin
                            full_d[wr_bank_q] = 1'b1;
                            wr_bank_d         = ~wr_bank_q;
                            wr_idx_d          = '0;
                            if (full_d[~wr_bank_q]) begin
                                state_d = ST_STALL;
                            end
                        end else begin
                            wr_idx_d = wr_idx_q + ADDR_BITS'(1);
                        end
                    end
                end
                ST_STALL: begin
                    if (edge_q) begin
                        overrun_d = 1'b1;
`ifdef I2S_FRAME_OVERRUN_CNT_EN
                        if (~&cnt_q) begin
                            cnt_d = cnt_q + OVR_CNT_BITS'(1);
                        end
`endif
                    end
                    if (!full_d[wr_bank_q]) begin
                        state_d  = ST_FILL;
                        wr_idx_d = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wr_bank_q <= 1'b0;
            wr_idx_q  <= '0;
            full_q    <= '0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b0;
            bank_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_bank_q <= wr_bank_d;
            wr_idx_q  <= wr_idx_d;
            full_q    <= full_d;
            valid_q   <= valid_d;
            ready_q   <= |full_d;
            bank_q    <= oldest_bank(full_d, wr_bank_d);
            overrun_q <= overrun_d;
        end
    end

`ifdef I2S_FRAME_OVERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign overrun_cnt_o = cnt_q;
`endif

    i2s_frame_buffer_dpram #(
        .DATA_BITS (DATA_BITS),
        .ADDR_BITS (RAM_ADDR_BITS)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en_c),
        .wr_addr_i ({wr_bank_q, wr_idx_q}),
        .wr_data_i (mono_q),
        .rd_addr_i ({bank_q, frame_rd_addr_i}),
        .rd_data_o (frame_rd_data_o)
    );

    assign i2s_get_o      = get_q;
    assign sample_valid_o = valid_q;
    assign frame_ready_o  = ready_q;
    assign frame_bank_o   = bank_q;
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_i2s_frame_buffer.sv
// Directed bench for i2s_frame_buffer with FRAME_LEN=8; also covers I2S_FRAME_OVERRUN_CNT_EN builds.
module tb_i2s_frame_buffer;

    localparam int unsigned DB = 16;
    localparam int unsigned FL = 8;
    localparam int unsigned AB = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable_i = 1'b0;
    logic          i2s_get_o;
    logic [DB-1:0] l_i = '0;
    logic [DB-1:0] r_i = '0;
    logic          done_i = 1'b0;
    logic          sample_valid_o;
    logic          frame_ready_o;
    logic          frame_bank_o;
    logic [AB-1:0] rd_addr_i = '0;
    logic [DB-1:0] rd_data_o;
    logic          release_i = 1'b0;
    logic          overrun_o;
`ifdef I2S_FRAME_OVERRUN_CNT_EN
    logic [15:0]   overrun_cnt_o;
`endif

    int errors = 0;
    int checks = 0;
    int vcount = 0;
    int vbase;

    logic [DB-1:0] vec_l   [FL] = '{16'h7FFF, 16'h8000, 16'h0001, 16'h0003,
                                    16'h0010, 16'hFFF0, 16'h1234, 16'hFFFF};
    logic [DB-1:0] vec_r   [FL] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000,
                                    16'h0030, 16'hFFF0, 16'h1234, 16'h0000};
    logic [DB-1:0] vec_exp [FL] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h0001,
                                    16'h0020, 16'hFFF0, 16'h1234, 16'hFFFF};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sample_valid_o === 1'b1) vcount++;
    end

    i2s_frame_buffer #(
        .DATA_BITS (DB),
        .FRAME_LEN (FL)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .enable_i            (enable_i),
        .i2s_get_o           (i2s_get_o),
        .i2s_sample_data_L_i (l_i),
        .i2s_sample_data_R_i (r_i),
        .i2s_done_i          (done_i),
        .sample_valid_o      (sample_valid_o),
        .frame_ready_o       (frame_ready_o),
        .frame_bank_o        (frame_bank_o),
        .frame_rd_addr_i     (rd_addr_i),
        .frame_rd_data_o     (rd_data_o),
        .frame_release_i     (release_i),
        .overrun_o           (overrun_o)
`ifdef I2S_FRAME_OVERRUN_CNT_EN
        ,
        .overrun_cnt_o       (overrun_cnt_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // One done window; done first sampled at the 1st posedge after it rises.
    task automatic pulse(input logic [DB-1:0] l, input logic [DB-1:0] r);
        @(posedge clk);
        #3;
        l_i = l;
        r_i = r;
        done_i = 1'b1;
        repeat (6) @(posedge clk);
        #3 done_i = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    // Same window, with release held for the cycle ending at the RAM-write edge (3rd clk after sampling).
    task automatic pulse_rel(input logic [DB-1:0] l, input logic [DB-1:0] r);
        @(posedge clk);
        #3;
        l_i = l;
        r_i = r;
        done_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 release_i = 1'b1;
        @(posedge clk);
        #1 release_i = 1'b0;
        repeat (2) @(posedge clk);
        #3 done_i = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic release_bank();
        @(posedge clk);
        #1 release_i = 1'b1;
        @(posedge clk);
        #1 release_i = 1'b0;
    endtask

    task automatic rd_check(input string tag, input int idx, input logic [DB-1:0] exp);
        @(negedge clk);
        rd_addr_i = AB'(idx);
        @(posedge clk);
        #1;
        check($sformatf("%s_%0d", tag, idx), 32'(rd_data_o), 32'(exp));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_get"}, 32'(i2s_get_o), 32'h0);
        check({tag, "_valid"}, 32'(sample_valid_o), 32'h0);
        check({tag, "_ready"}, 32'(frame_ready_o), 32'h0);
        check({tag, "_bank"}, 32'(frame_bank_o), 32'h0);
        check({tag, "_rdata"}, 32'(rd_data_o), 32'h0);
        check({tag, "_ovr"}, 32'(overrun_o), 32'h0);
`ifdef I2S_FRAME_OVERRUN_CNT_EN
        check({tag, "_cnt"}, 32'(overrun_cnt_o), 32'h0);
`endif
    endtask

    task automatic pulse_rst(input string tag);
        @(posedge clk);
        #1 rst = 1'b1;
        settle();
        check_reset_outputs(tag);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        rst = 1'b0;

        // First fill: discard edge, then the mix vectors into bank 0
        enable_i = 1'b1;
        settle();
        check("get_on", 32'(i2s_get_o), 32'h1);
        pulse(16'h1234, 16'h1234);
        check("arm_discard", 32'(vcount), 32'd0);
        for (int i = 0; i < FL; i++) pulse(vec_l[i], vec_r[i]);
        settle();
        check("fill0_cnt", 32'(vcount), 32'(FL));
        check("fill0_ready", 32'(frame_ready_o), 32'h1);
        check("fill0_bank", 32'(frame_bank_o), 32'h0);
        check("fill0_ovr", 32'(overrun_o), 32'h0);
        for (int i = 0; i < FL; i++) rd_check("mix", i, vec_exp[i]);

        // No release: bank 1 fills, then three edges are dropped
        for (int i = 0; i < FL; i++) pulse(16'h0100 + DB'(i), 16'h0100 + DB'(i));
        for (int i = 0; i < 3; i++) pulse(16'h7777, 16'h7777);
        settle();
        check("ovr_cnt_valid", 32'(vcount), 32'(2 * FL));
        check("ovr_flag", 32'(overrun_o), 32'h1);
        check("ovr_ready", 32'(frame_ready_o), 32'h1);
        check("ovr_bank", 32'(frame_bank_o), 32'h0);
`ifdef I2S_FRAME_OVERRUN_CNT_EN
        check("ovr_count", 32'(overrun_cnt_o), 32'd3);
`endif
        for (int i = 0; i < FL; i++) rd_check("bank0_kept", i, vec_exp[i]);

        // Release in STALL: bank 1 offered, filling resumes
        release_bank();
        settle();
        check("stall_rel_ready", 32'(frame_ready_o), 32'h1);
        check("stall_rel_bank", 32'(frame_bank_o), 32'h1);
        for (int i = 0; i < FL; i++) rd_check("bank1", i, 16'h0100 + DB'(i));
        pulse(16'h0040, 16'h0040);
        settle();
        check("resume_valid", 32'(vcount), 32'(2 * FL + 1));
        check("resume_ovr", 32'(overrun_o), 32'h1);

        // Reset mid-FILL
        pulse_rst("rst_fill");

        // Release in the same cycle bank 1 completes
        vbase = vcount;
        pulse(16'h1111, 16'h1111);
        for (int i = 0; i < FL; i++) pulse(16'h0300 + DB'(i), 16'h0300 + DB'(i));
        for (int i = 0; i < FL - 1; i++) pulse(16'h0310 + DB'(i), 16'h0310 + DB'(i));
        settle();
        check("pre_rel_bank", 32'(frame_bank_o), 32'h0);
        pulse_rel(16'h0317, 16'h0317);
        settle();
        check("same_ovr", 32'(overrun_o), 32'h0);
        check("same_ready", 32'(frame_ready_o), 32'h1);
        check("same_bank", 32'(frame_bank_o), 32'h1);
        pulse(16'h0050, 16'h0050);
        settle();
        check("same_valid", 32'(vcount), 32'(vbase + 2 * FL + 1));
        check("same_ovr2", 32'(overrun_o), 32'h0);

        // Enable drop after FRAME_LEN/2 samples, then a fresh fill of bank 0
        for (int i = 0; i < FL / 2 - 1; i++) pulse(16'h0060, 16'h0060);
        @(posedge clk);
        #1 enable_i = 1'b0;
        repeat (3) settle();
        check("dis_get", 32'(i2s_get_o), 32'h0);
        check("dis_ready", 32'(frame_ready_o), 32'h1);
        check("dis_bank", 32'(frame_bank_o), 32'h1);
        enable_i = 1'b1;
        vbase = vcount;
        pulse(16'h2222, 16'h2222);
        check("rearm_discard", 32'(vcount), 32'(vbase));
        for (int i = 0; i < FL; i++) pulse(16'h0200 + DB'(i), 16'h0200 + DB'(i));
        settle();
        check("refill_valid", 32'(vcount), 32'(vbase + FL));
        check("refill_bank", 32'(frame_bank_o), 32'h1);
        for (int i = 0; i < 2; i++) rd_check("old_bank1", i, 16'h0310 + DB'(i));
        release_bank();
        settle();
        check("refill_rel_bank", 32'(frame_bank_o), 32'h0);
        for (int i = 0; i < FL; i++) rd_check("fresh", i, 16'h0200 + DB'(i));

        // Reach STALL again, drop one edge, then reset
        for (int i = 0; i < FL; i++) pulse(16'h0400 + DB'(i), 16'h0400 + DB'(i));
        pulse(16'h7777, 16'h7777);
        settle();
        check("stall2_ovr", 32'(overrun_o), 32'h1);
`ifdef I2S_FRAME_OVERRUN_CNT_EN
        check("stall2_count", 32'(overrun_cnt_o), 32'd1);
`endif
        pulse_rst("rst_stall");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
